// File: rtl/femto_reset_pkg.sv
// femto_reset_pkg: shared FSM state encoding and counter-width helper for the reset sequencer
package femto_reset_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    PERIPH    = 2'd2,
    RUN       = 2'd3
  } state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/femto_reset_seq_if.sv
// femto_reset_seq_if: PLL/button inputs and ordered reset outputs of the reset sequencer
// pll_locked (1=locked), btn_n (0=pressed) flow master->slave;
// periph_resetn, sys_resetn (active low) and busy flow slave->master.
interface femto_reset_seq_if;
  logic pll_locked;
  logic btn_n;
  logic periph_resetn;
  logic sys_resetn;
  logic busy;
  modport master (output pll_locked, btn_n, input periph_resetn, sys_resetn, busy);
  modport slave (input pll_locked, btn_n, output periph_resetn, sys_resetn, busy);
endinterface

// File: rtl/femto_sync.sv
// femto_sync: STAGES-deep single-bit synchronizer with selectable reset value
// clk: sampling clock; resetn: sync active-low reset; i_d: async input; o_q: synchronized output
module femto_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge clk)
    if (!resetn) r_chain <= {STAGES{RST_VAL}};
    else         r_chain <= {r_chain[STAGES-2:0], i_d};
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/femto_reset_seq.sv
// femto_reset_seq: turns PLL lock and reset button into ordered peripheral-then-CPU resets
// clk: PLL output clock; resetn: sync active-low block reset;
// bus (slave): pll_locked, btn_n in; periph_resetn, sys_resetn, busy out.
module femto_reset_seq
  import femto_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int PERIPH_DELAY    = 8
) (
  input logic              clk,
  input logic              resetn,
  femto_reset_seq_if.slave bus
);
  localparam int HW = cnt_w(HOLD_CYCLES > PERIPH_DELAY ? HOLD_CYCLES : PERIPH_DELAY);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] PER_LAST  = HW'(PERIPH_DELAY - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  logic          w_lock_s, w_btn_s, w_db_flip, w_pressed, w_abort;
  logic          r_btn_db, r_periph, r_sys;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  state_t        r_state, w_state_nxt;
  femto_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .clk(clk), .resetn(resetn), .i_d(bus.pll_locked), .o_q(w_lock_s)
  );
  femto_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_btn_sync (
    .clk(clk), .resetn(resetn), .i_d(bus.btn_n), .o_q(w_btn_s)
  );
  // debounced level only follows btn_s after it has differed for DEBOUNCE_CYCLES edges in a row
  assign w_db_flip = (w_btn_s != r_btn_db) && (r_dcnt == DEB_LAST);
  assign w_pressed = ~r_btn_db;
  assign w_abort   = ~w_lock_s | w_pressed;
  always_ff @(posedge clk)
    if (!resetn) begin
      r_btn_db <= 1'b1;
      r_dcnt   <= '0;
    end else begin
      r_btn_db <= w_db_flip ? w_btn_s : r_btn_db;
      r_dcnt   <= (w_btn_s == r_btn_db || w_db_flip) ? '0 : r_dcnt + 1'b1;
    end
  // abort is tested before counter completion so it always wins in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    unique case (r_state)
      WAIT_LOCK: begin
        w_state_nxt = (w_lock_s && !w_pressed) ? HOLD : WAIT_LOCK;
        w_hcnt_nxt  = '0;
      end
      HOLD: begin
        w_state_nxt = w_abort ? WAIT_LOCK : (r_hcnt == HOLD_LAST) ? PERIPH : HOLD;
        w_hcnt_nxt  = (w_abort || r_hcnt == HOLD_LAST) ? '0 : r_hcnt + 1'b1;
      end
      PERIPH: begin
        w_state_nxt = w_abort ? WAIT_LOCK : (r_hcnt == PER_LAST) ? RUN : PERIPH;
        w_hcnt_nxt  = (w_abort || r_hcnt == PER_LAST) ? '0 : r_hcnt + 1'b1;
      end
      RUN: begin
        w_state_nxt = w_abort ? WAIT_LOCK : RUN;
        w_hcnt_nxt  = '0;
      end
    endcase
  end
  // outputs are registered from the next state so they change on the same edge as the state, glitch-free
  always_ff @(posedge clk)
    if (!resetn) begin
      r_state  <= WAIT_LOCK;
      r_hcnt   <= '0;
      r_periph <= 1'b0;
      r_sys    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_periph <= (w_state_nxt == PERIPH) || (w_state_nxt == RUN);
      r_sys    <= (w_state_nxt == RUN);
    end
  assign bus.periph_resetn = r_periph;
  assign bus.sys_resetn    = r_sys;
  assign bus.busy          = ~r_sys;
endmodule
